// File: rtl/midi_uart_tx.sv
// midi_uart_tx: UART/MIDI serial transmitter with an input byte FIFO.
// Frames are start, LSB-first data, optional parity, stop bits; queued frames go out back-to-back.
`default_nettype none

module midi_uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 38400,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);
  localparam logic          ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            level_q, level_d;

  logic                   bit_end;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic [DATA_BITS-1:0]   head;

  assign bit_end  = (cnt_q == LAST_CNT);
  assign empty    = (level_q == '0);
  assign full     = (level_q == DEPTH);
  assign push     = wr_en && !full;
  assign overflow = wr_en && full;
  assign head     = mem[rd_ptr_q];

  assign level = level_q;
  assign busy  = (state_q != S_IDLE) || !empty;
  assign tx    = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    // tx_d reflects the current state, so the line trails the state by one cycle
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        tx_d = par_q;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            idx_d = '0;
            if (!empty) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d = head;
      par_d   = (^head) ^ ODD;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_midi_uart_tx.sv
// Directed bench for midi_uart_tx: timing, framing, FIFO limits, parity, reset abort, default baud.
`timescale 1ns/1ps
`default_nettype none

module tb_midi_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       b_wr_en, e_wr_en, o_wr_en, d_wr_en;
  logic [7:0] b_wr_data, e_wr_data, o_wr_data, d_wr_data;
  logic       b_full, e_full, o_full, d_full;
  logic [2:0] b_level, e_level, o_level, d_level;
  logic       b_ovf, e_ovf, o_ovf, d_ovf;
  logic       b_busy, e_busy, o_busy, d_busy;
  logic       b_tx, e_tx, o_tx, d_tx;

  midi_uart_tx #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_base (
    .clk(clk), .reset_n(reset_n), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .full(b_full), .level(b_level), .overflow(b_ovf), .busy(b_busy), .tx(b_tx));

  midi_uart_tx #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
    .clk(clk), .reset_n(reset_n), .wr_en(e_wr_en), .wr_data(e_wr_data),
    .full(e_full), .level(e_level), .overflow(e_ovf), .busy(e_busy), .tx(e_tx));

  midi_uart_tx #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_odd (
    .clk(clk), .reset_n(reset_n), .wr_en(o_wr_en), .wr_data(o_wr_data),
    .full(o_full), .level(o_level), .overflow(o_ovf), .busy(o_busy), .tx(o_tx));

  midi_uart_tx u_def (
    .clk(clk), .reset_n(reset_n), .wr_en(d_wr_en), .wr_data(d_wr_data),
    .full(d_full), .level(d_level), .overflow(d_ovf), .busy(d_busy), .tx(d_tx));

  function automatic logic tx_of(input int k);
    case (k)
      0:       return b_tx;
      1:       return e_tx;
      2:       return o_tx;
      default: return d_tx;
    endcase
  endfunction

  // Waits (bounded) for a start bit, then samples nbits at bit centres; bits[0] is the start bit.
  task automatic rx(input int k, input int nbits, input int cpb, input int limit,
                    output logic [15:0] bits, output int st, output bit ok);
    int n;
    bits = '0;
    st   = 0;
    ok   = 1'b0;
    n    = 0;
    while (n < limit && tx_of(k) !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    if (tx_of(k) === 1'b0) begin
      ok = 1'b1;
      st = cyc;
      repeat (cpb / 2) @(negedge clk);
      bits[0] = tx_of(k);
      for (int i = 1; i < nbits; i++) begin
        repeat (cpb) @(negedge clk);
        bits[i] = tx_of(k);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    b_wr_en = 1'b0; e_wr_en = 1'b0; o_wr_en = 1'b0; d_wr_en = 1'b0;
    b_wr_data = '0; e_wr_data = '0; o_wr_data = '0; d_wr_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (b_tx !== 1'b1 || b_full !== 1'b0 || b_level !== 3'd0 || b_ovf !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state tx=%b full=%b level=%0d ovf=%b busy=%b expected 1 0 0 0 0",
               b_tx, b_full, b_level, b_ovf, b_busy);
    end
    checks++;
    if (d_tx !== 1'b1 || d_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_default tx=%b busy=%b expected tx=1 busy=0", d_tx, d_busy);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [15:0] bits;
    int st;
    bit ok;
    b_wr_en = 1'b1; b_wr_data = 8'h90;
    @(negedge clk);
    b_wr_en = 1'b0;
    checks++;
    if (b_level !== 3'd1 || b_tx !== 1'b1 || b_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_write level=%0d tx=%b busy=%b expected 1 1 1", b_level, b_tx, b_busy);
    end
    @(negedge clk);
    checks++;
    if (b_level !== 3'd0 || b_tx !== 1'b1) begin
      errors++;
      $display("FAIL single_pop level=%0d tx=%b expected level=0 tx=1", b_level, b_tx);
    end
    @(negedge clk);
    checks++;
    if (b_tx !== 1'b0) begin
      errors++;
      $display("FAIL single_start_latency tx=%b expected 0", b_tx);
    end
    rx(0, 10, 16, 4, bits, st, ok);
    checks++;
    if (!ok || bits[9:0] !== {1'b1, 8'h90, 1'b0}) begin
      errors++;
      $display("FAIL single_frame bits=%h ok=%0d expected %h", bits[9:0], ok, {1'b1, 8'h90, 1'b0});
    end
    // state leaves STOP 159 cycles after tx first goes low
    repeat (6) @(negedge clk);
    checks++;
    if (b_busy !== 1'b1 || b_tx !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_end busy=%b tx=%b expected busy=1 tx=1", b_busy, b_tx);
    end
    @(negedge clk);
    checks++;
    if (b_busy !== 1'b0 || b_tx !== 1'b1) begin
      errors++;
      $display("FAIL single_idle busy=%b tx=%b expected busy=0 tx=1", b_busy, b_tx);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    logic [7:0]  exp_b [3];
    int st [3];
    bit ok;
    int n;
    exp_b[0] = 8'h90; exp_b[1] = 8'h40; exp_b[2] = 8'h20;
    for (int i = 0; i < 3; i++) begin
      b_wr_en = 1'b1; b_wr_data = exp_b[i];
      @(negedge clk);
    end
    b_wr_en = 1'b0;
    checks++;
    if (b_level !== 3'd2) begin
      errors++;
      $display("FAIL b2b_level level=%0d expected 2", b_level);
    end
    for (int i = 0; i < 3; i++) begin
      rx(0, 10, 16, 400, bits, st[i], ok);
      checks++;
      if (!ok || bits[8:1] !== exp_b[i] || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_byte%0d got=%h ok=%0d expected %h", i, bits[8:1], ok, exp_b[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (st[i] - st[i-1] !== 160) begin
        errors++;
        $display("FAIL b2b_gap%0d spacing=%0d expected 160", i, st[i] - st[i-1]);
      end
    end
    n = 0;
    while (n < 100 && b_busy !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b expected 0", b_busy);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [15:0] bits;
    int st;
    bit ok;
    int ovf_cnt;
    ovf_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      b_wr_en = 1'b1; b_wr_data = 8'hA1 + 8'(i);
      #1;
      if (b_ovf === 1'b1) ovf_cnt++;
      if (i == 5) begin
        checks++;
        if (b_full !== 1'b1) begin
          errors++;
          $display("FAIL ovf_full_on_6th full=%b expected 1", b_full);
        end
      end
      @(negedge clk);
    end
    b_wr_en = 1'b0;
    #1;
    if (b_ovf === 1'b1) ovf_cnt++;
    checks++;
    if (ovf_cnt !== 1 || b_level !== 3'd4) begin
      errors++;
      $display("FAIL ovf_pulse pulses=%0d level=%0d expected 1 and 4", ovf_cnt, b_level);
    end
    for (int i = 0; i < 5; i++) begin
      rx(0, 10, 16, 400, bits, st, ok);
      checks++;
      if (!ok || bits[8:1] !== 8'hA1 + 8'(i)) begin
        errors++;
        $display("FAIL ovf_byte%0d got=%h ok=%0d expected %h", i, bits[8:1], ok, 8'hA1 + 8'(i));
      end
    end
    rx(0, 1, 16, 100, bits, st, ok);
    checks++;
    if (ok) begin
      errors++;
      $display("FAIL ovf_extra_frame frame_seen=%0d expected 0", ok);
    end
  endtask

  task automatic test_parity();
    logic [15:0] bits;
    int st0, st1;
    bit ok;
    e_wr_en = 1'b1; e_wr_data = 8'h07;
    @(negedge clk);
    e_wr_en = 1'b0;
    rx(1, 11, 16, 10, bits, st0, ok);
    checks++;
    if (!ok || bits[10:0] !== {1'b1, 1'b1, 8'h07, 1'b0}) begin
      errors++;
      $display("FAIL parity_even bits=%h ok=%0d expected %h", bits[10:0], ok, {1'b1, 1'b1, 8'h07, 1'b0});
    end
    o_wr_en = 1'b1; o_wr_data = 8'h07;
    @(negedge clk);
    @(negedge clk);
    o_wr_en = 1'b0;
    rx(2, 12, 16, 10, bits, st0, ok);
    checks++;
    if (!ok || bits[11:0] !== {2'b11, 1'b0, 8'h07, 1'b0}) begin
      errors++;
      $display("FAIL parity_odd bits=%h ok=%0d expected %h", bits[11:0], ok, {2'b11, 1'b0, 8'h07, 1'b0});
    end
    rx(2, 12, 16, 100, bits, st1, ok);
    checks++;
    if (!ok || st1 - st0 !== 192) begin
      errors++;
      $display("FAIL stop2_frame_len len=%0d ok=%0d expected 192", st1 - st0, ok);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [15:0] bits;
    int st;
    bit ok;
    int n;
    b_wr_en = 1'b1; b_wr_data = 8'h00;
    @(negedge clk);
    b_wr_data = 8'h90;
    @(negedge clk);
    b_wr_data = 8'h40;
    @(negedge clk);
    b_wr_en = 1'b0;
    checks++;
    if (b_level !== 3'd2) begin
      errors++;
      $display("FAIL abort_queued level=%0d expected 2", b_level);
    end
    n = 0;
    while (n < 10 && b_tx !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    repeat (24) @(negedge clk);
    checks++;
    if (b_tx !== 1'b0) begin
      errors++;
      $display("FAIL abort_mid_data tx=%b expected 0", b_tx);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (b_tx !== 1'b1 || b_level !== 3'd0 || b_busy !== 1'b0 || b_full !== 1'b0) begin
      errors++;
      $display("FAIL abort_async tx=%b level=%0d busy=%b full=%b expected 1 0 0 0",
               b_tx, b_level, b_busy, b_full);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rx(0, 1, 16, 300, bits, st, ok);
    checks++;
    if (ok || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_frames frame_seen=%0d busy=%b expected 0 0", ok, b_busy);
    end
  endtask

  task automatic test_default_baud();
    int n, prev, c0;
    d_wr_en = 1'b1; d_wr_data = 8'h55;
    @(negedge clk);
    d_wr_en = 1'b0;
    n = 0;
    while (n < 10 && d_tx !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    c0 = cyc;
    prev = c0;
    // 0x55 alternates every bit, so each edge on tx marks a bit boundary
    for (int i = 1; i < 10; i++) begin
      n = 0;
      while (n < 1400 && d_tx !== 1'(i % 2)) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (cyc - prev !== 1302) begin
        errors++;
        $display("FAIL default_bit%0d width=%0d expected 1302", i - 1, cyc - prev);
      end
      prev = cyc;
    end
    n = 0;
    while (n < 1400 && d_busy !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    // busy falls one cycle before the registered line finishes the stop bit
    checks++;
    if (d_busy !== 1'b0 || cyc - c0 + 1 !== 13020) begin
      errors++;
      $display("FAIL default_frame_len len=%0d busy=%b expected 13020 0", cyc - c0 + 1, d_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_reset_abort();
    test_default_baud();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
